// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS/CTRL bit positions, serializer states and the bit-period rule.
package uart_pkg;

    // Register offsets, selected by IEUAdr[3:2]
    localparam logic [1:0] OFS_TXDATA  = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_BAUDDIV = 2'd2;
    localparam logic [1:0] OFS_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int STS_EMPTY = 0;
    localparam int STS_FULL  = 1;
    localparam int STS_BUSY  = 2;
    localparam int STS_OVF   = 3;

    // CTRL bit positions
    localparam int CTRL_IE = 0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    // A divider of zero would stall the serializer, so it is treated as one cycle per bit.
    function automatic logic [15:0] bit_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory port of the core as seen by a memory-mapped responder.
interface mmio_uart_tx_if;
    logic [31:0] IEUAdr;
    logic        MemEn;
    logic        WriteEn;
    logic [3:0]  WriteByteEn;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output IEUAdr, MemEn, WriteEn, WriteByteEn, WriteData,
        input  ReadData
    );

    modport slave (
        input  IEUAdr, MemEn, WriteEn, WriteByteEn, WriteData,
        output ReadData
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate counter. Pushes into a full FIFO and
// pops from an empty one are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == DEPTH_W);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    // Advance each pointer only on an accepted operation
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; emptiness is tracked by the pointers alone.
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXDATA fill a FIFO that the
// serializer drains onto TxD; ReadData is combinational from registered state
// so loads complete in the same cycle.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            TxD,
    output logic            TxIrq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Bus decode
    logic       sel, wr, rd, push;
    logic [1:0] ofs;

    // Register state
    logic [15:0] baud_div_q, baud_div_d;
    logic        ie_q, ie_d;
    logic        ovf_q, ovf_d;

    // Serializer state
    uart_tx_state_t state_q, state_d;
    logic           txd_q, txd_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]    baud_cnt_q, baud_cnt_d;
    logic [15:0]    period;
    logic           bit_done;

    // FIFO connection
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [AW:0] unused_fifo_count;
    logic        unused_bus_bits;

    logic [31:0] read_data;

    assign sel  = bus.MemEn && (bus.IEUAdr[31:4] == BASE_ADR[31:4]);
    assign wr   = sel && bus.WriteEn;
    assign rd   = sel && !bus.WriteEn;
    assign ofs  = bus.IEUAdr[3:2];
    assign push = wr && (ofs == OFS_TXDATA) && bus.WriteByteEn[0];

    assign unused_bus_bits = ^{bus.IEUAdr[1:0], bus.WriteByteEn[3:2], bus.WriteData[31:16]};

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (fifo_pop),
        .din   (bus.WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    // Register writes: byte-lane BAUDDIV, CTRL.IE, sticky overflow with W1C
    always_comb begin
        baud_div_d = baud_div_q;
        ie_d       = ie_q;
        ovf_d      = ovf_q;
        if (wr && ofs == OFS_BAUDDIV) begin
            if (bus.WriteByteEn[0]) baud_div_d[7:0]  = bus.WriteData[7:0];
            if (bus.WriteByteEn[1]) baud_div_d[15:8] = bus.WriteData[15:8];
        end
        if (wr && ofs == OFS_CTRL && bus.WriteByteEn[0]) ie_d = bus.WriteData[CTRL_IE];
        if (wr && ofs == OFS_STATUS && bus.WriteByteEn[0] && bus.WriteData[STS_OVF]) ovf_d = 1'b0;
        // A dropped push wins over a simultaneous clear so the loss is never hidden
        if (push && fifo_full) ovf_d = 1'b1;
    end

    // Load data mux; zero whenever this block is not being read
    always_comb begin
        read_data = '0;
        if (rd) begin
            case (ofs)
                OFS_STATUS: begin
                    read_data[STS_EMPTY] = fifo_empty;
                    read_data[STS_FULL]  = fifo_full;
                    read_data[STS_BUSY]  = (state_q != IDLE);
                    read_data[STS_OVF]   = ovf_q;
                end
                OFS_BAUDDIV: read_data[15:0]    = baud_div_q;
                OFS_CTRL:    read_data[CTRL_IE] = ie_q;
                default:     read_data = '0;
            endcase
        end
    end

    assign bus.ReadData = read_data;

    assign period   = bit_period(baud_div_q);
    assign bit_done = (baud_cnt_q <= 16'd1);

    // Serializer next state: start bit, 8 data bits LSB first, stop bit, chained frames
    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_d    = START;
                    txd_d      = 1'b0;
                    shift_d    = fifo_dout;
                    bit_cnt_d  = '0;
                    baud_cnt_d = period;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d    = DATA;
                    txd_d      = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                    baud_cnt_d = period;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_d = period;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        state_d    = START;
                        txd_d      = 1'b0;
                        shift_d    = fifo_dout;
                        bit_cnt_d  = '0;
                        baud_cnt_d = period;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State registers; reset returns the line to idle-high at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_div_q <= DEFAULT_DIV;
            ie_q       <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            txd_q      <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else begin
            baud_div_q <= baud_div_d;
            ie_q       <= ie_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            txd_q      <= txd_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

    assign TxD   = txd_q;
    assign TxIrq = ie_q && fifo_empty && (state_q == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-access vector table, directed
// serial-frame sequences, and randomized bursts compared against an ideal
// 8N1 waveform computed from the byte list and bit period.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
    localparam logic [15:0] DDIV  = 16'd868;
    localparam logic [31:0] A_TX  = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_BD  = BASE + 32'h8;
    localparam logic [31:0] A_CT  = BASE + 32'hC;

    logic clk = 1'b0;
    logic reset;
    logic txd;
    logic tx_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] wave_q[$];

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADR    (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .TxD   (txd),
        .TxIrq (tx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        men;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic men, logic we, logic [31:0] adr,
                                logic [3:0] be, logic [31:0] wd, logic [31:0] exp_rd);
        vec_t v;
        v.name = name; v.men = men; v.we = we; v.adr = adr;
        v.be = be; v.wd = wd; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // All bus tasks enter and leave on a falling clock edge
    task automatic bus_write(logic [31:0] a, logic [31:0] d, logic [3:0] be);
        bus.IEUAdr = a; bus.WriteData = d; bus.WriteByteEn = be;
        bus.WriteEn = 1'b1; bus.MemEn = 1'b1;
        @(negedge clk);
        bus.MemEn = 1'b0; bus.WriteEn = 1'b0;
    endtask

    task automatic bus_read(logic [31:0] a, output logic [31:0] d);
        bus.IEUAdr = a; bus.WriteEn = 1'b0; bus.MemEn = 1'b1;
        #1 d = bus.ReadData;
        @(negedge clk);
        bus.MemEn = 1'b0;
    endtask

    task automatic check_read(string name, logic [31:0] a, logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Ideal 8N1 line level for bit k (0=start, 1..8 data LSB first, 9=stop)
    function automatic logic frame_bit(logic [7:0] b, int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Compares TxD every cycle against back-to-back frames of wave_q, starting now
    task automatic expect_wave(int p);
        for (int f = 0; f < wave_q.size(); f++)
            for (int k = 0; k < 10; k++)
                for (int c = 0; c < p; c++) begin
                    check($sformatf("txd_f%0d_b%0d_c%0d", f, k, c), 32'(txd), 32'(frame_bit(wave_q[f], k)));
                    tick(1);
                end
    endtask

    // Counts low TxD cycles over a window; an idle line never goes low
    task automatic expect_idle(string name, int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            if (txd !== 1'b1) lows++;
            tick(1);
        end
        check(name, lows, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata [DEPTH+2];
        int          k, p, lows;
        logic [15:0] div;

        bus.IEUAdr = '0; bus.MemEn = 1'b0; bus.WriteEn = 1'b0;
        bus.WriteByteEn = '0; bus.WriteData = '0;
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);

        check("txd_reset", 32'(txd), 32'h1);
        check("irq_reset", 32'(tx_irq), 32'h0);

        // ---------------- register access vectors ----------------
        vecs.push_back(mk("rd_status_rst",  1, 0, A_ST,             4'h0, 32'h0,         32'h1));
        vecs.push_back(mk("rd_bauddiv_rst", 1, 0, A_BD,             4'h0, 32'h0,         32'(DDIV)));
        vecs.push_back(mk("rd_ctrl_rst",    1, 0, A_CT,             4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("rd_txdata",      1, 0, A_TX,             4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("wr_bd_lane0",    1, 1, A_BD,             4'h1, 32'hFFFF_FF12, 32'h0));
        vecs.push_back(mk("rd_bd_lane0",    1, 0, A_BD,             4'h0, 32'h0,         32'h0312));
        vecs.push_back(mk("wr_bd_lane1",    1, 1, A_BD,             4'h2, 32'h0000_AB00, 32'h0));
        vecs.push_back(mk("rd_bd_lane1",    1, 0, A_BD,             4'h0, 32'h0,         32'hAB12));
        vecs.push_back(mk("wr_bd_upper",    1, 1, A_BD,             4'hC, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_bd_upper",    1, 0, A_BD,             4'h0, 32'h0,         32'hAB12));
        vecs.push_back(mk("wr_other_base",  1, 1, 32'h2000_0008,    4'hF, 32'h1,         32'h0));
        vecs.push_back(mk("rd_bd_lowbits",  1, 0, BASE + 32'hB,     4'h0, 32'h0,         32'hAB12));
        vecs.push_back(mk("wr_tx_no_lane0", 1, 1, A_TX,             4'h2, 32'hFFFF,      32'h0));
        vecs.push_back(mk("rd_status_nopush",1,0, A_ST,             4'h0, 32'h0,         32'h1));
        vecs.push_back(mk("wr_ctrl_lane1",  1, 1, A_CT,             4'h2, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_ctrl_lane1",  1, 0, A_CT,             4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("wr_ctrl_ie",     1, 1, A_CT,             4'h1, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("rd_ctrl_ie",     1, 0, A_CT,             4'h0, 32'h0,         32'h1));
        vecs.push_back(mk("wr_ctrl_clr",    1, 1, A_CT,             4'hF, 32'h0,         32'h0));
        vecs.push_back(mk("rd_ctrl_clr",    1, 0, A_CT,             4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("rd_unmapped",    1, 0, 32'h2000_0004,    4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("rd_next_block",  1, 0, BASE + 32'h10,    4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("rd_no_memen",    0, 0, A_ST,             4'h0, 32'h0,         32'h0));
        vecs.push_back(mk("wr_no_memen",    0, 1, A_BD,             4'hF, 32'h5,         32'h0));
        vecs.push_back(mk("rd_bd_after",    1, 0, A_BD,             4'h0, 32'h0,         32'hAB12));
        vecs.push_back(mk("wr_status_junk", 1, 1, A_ST,             4'h1, 32'hF7,        32'h0));
        vecs.push_back(mk("rd_status_junk", 1, 0, A_ST,             4'h0, 32'h0,         32'h1));

        foreach (vecs[i]) begin
            bus.MemEn = vecs[i].men; bus.WriteEn = vecs[i].we; bus.IEUAdr = vecs[i].adr;
            bus.WriteByteEn = vecs[i].be; bus.WriteData = vecs[i].wd;
            #1 check(vecs[i].name, bus.ReadData, vecs[i].exp_rd);
            @(negedge clk);
            bus.MemEn = 1'b0; bus.WriteEn = 1'b0;
        end

        // ---------------- single frame 0xA5, 4 cycles per bit ----------------
        bus_write(A_BD, 32'd4, 4'h3);
        wave_q = '{8'hA5};
        bus_write(A_TX, 32'hA5, 4'h1);
        check("txd_still_idle", 32'(txd), 32'h1);
        tick(1);
        expect_wave(4);
        check("txd_after_a5", 32'(txd), 32'h1);
        check_read("status_after_a5", A_ST, 32'h1);

        // ---------------- back-to-back frames ----------------
        wave_q = '{8'h55, 8'hAA};
        bus_write(A_TX, 32'h55, 4'h1);
        bus_write(A_TX, 32'hAA, 4'h1);
        expect_wave(4);
        check_read("status_after_b2b", A_ST, 32'h1);

        // ---------------- interrupt ----------------
        bus_write(A_CT, 32'h1, 4'h1);
        check("irq_idle_ie", 32'(tx_irq), 32'h1);
        bus_write(A_TX, 32'h3C, 4'h1);
        check("irq_after_push", 32'(tx_irq), 32'h0);
        tick(1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_irq !== 1'b0) lows++;
            tick(1);
        end
        check("irq_low_during_frame", lows, 0);
        check("irq_after_stop", 32'(tx_irq), 32'h1);
        bus_write(A_CT, 32'h0, 4'h1);
        check("irq_ie_off", 32'(tx_irq), 32'h0);

        // ---------------- overflow ----------------
        // The serializer takes the first byte one cycle after it lands, so
        // DEPTH+1 bytes are accepted and the last one is dropped.
        bus_write(A_BD, 32'd100, 4'h3);
        wave_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            rdata[i] = $urandom();
            if (i < DEPTH + 1) wave_q.push_back(rdata[i][7:0]);
        end
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) bus_write(A_TX, rdata[i], 4'h1);
                check_read("status_full_ovf", A_ST, 32'hE);
                bus_write(A_ST, 32'h8, 4'h1);
                check_read("status_ovf_cleared", A_ST, 32'h6);
                // Land a push on the edge where frame 0 ends and the head is popped
                tick(988);
                bus_write(A_TX, 32'hEE, 4'h1);
                check_read("status_ovf_on_pop", A_ST, 32'hC);
            end
            begin
                tick(2);
                expect_wave(100);
            end
        join
        check_read("status_after_ovf", A_ST, 32'h9);
        bus_write(A_ST, 32'h8, 4'h1);
        check_read("status_ovf_w1c", A_ST, 32'h1);
        expect_idle("no_dropped_frames", 250);

        // ---------------- randomized bursts ----------------
        for (int r = 0; r < 6; r++) begin
            div = 16'($urandom_range(0, 5));
            p   = (div == 16'd0) ? 1 : int'(div);
            bus_write(A_BD, {$urandom(), div} >> 0 & 32'h0000_FFFF | 32'(div), 4'h3);
            k = $urandom_range(1, DEPTH);
            wave_q.delete();
            for (int i = 0; i < k; i++) begin
                rdata[i] = $urandom();
                wave_q.push_back(rdata[i][7:0]);
            end
            fork
                begin
                    for (int i = 0; i < k; i++) bus_write(A_TX, rdata[i], 4'h1);
                end
                begin
                    tick(2);
                    expect_wave(p);
                end
            join
            check($sformatf("rand%0d_txd_idle", r), 32'(txd), 32'h1);
            check_read($sformatf("rand%0d_status", r), A_ST, 32'h1);
            tick($urandom_range(0, 5));
        end

        // ---------------- asynchronous reset mid-frame ----------------
        bus_write(A_BD, 32'd4, 4'h3);
        bus_write(A_TX, 32'h00, 4'h1);
        bus_write(A_TX, 32'h00, 4'h1);
        bus_write(A_TX, 32'h00, 4'h1);
        tick(8);
        check("txd_data_before_reset", 32'(txd), 32'h0);
        reset = 1'b0;
        #1 check("txd_async_reset", 32'(txd), 32'h1);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_read("status_after_reset", A_ST, 32'h1);
        check_read("bauddiv_after_reset", A_BD, 32'(DDIV));
        expect_idle("no_residual_frame", 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
